beep_pattern_player: RTL and testbench
======================================

BEEP_PATTERN_PLAYER -- requirements
Module: beep_pattern_player

Interface
REQ-001 Parameter PAT_LEN, 8, number of steps in one pattern.
REQ-002 Parameter N_PAT, 4, number of stored patterns.
REQ-003 Parameter SEL_W, 2, width of pat_sel; 2**SEL_W >= N_PAT.
REQ-004 Parameter PATTERNS, {8'h00,8'h00,8'h88,8'h55}, N_PAT*PAT_LEN-bit table; pattern p step s = bit p*PAT_LEN+s (0x55 = lose, 0x88 = win).
REQ-005 Parameter STEP_CYCLES, 12500000, clk cycles per step (4 Hz at 50 MHz).
REQ-006 Parameter TONE_HALF, 12500, clk cycles per tone half-period (2 kHz at 50 MHz).
REQ-007 Parameter REP_W, 4, width of repeat_n.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 en  in  1  sound enable; 0 aborts and silences.
REQ-011 mute  in  1  forces beep_out 0; sequencing continues.
REQ-012 start  in  1  single-cycle request to play pat_sel.
REQ-013 pat_sel  in  SEL_W  pattern index; values >= N_PAT play silence.
REQ-014 repeat_n  in  REP_W  extra plays; total plays = repeat_n+1.
REQ-015 tone_mode  in  1  0 = level output, 1 = gated square tone.
REQ-016 beep_out  out  1  registered buzzer drive.
REQ-017 busy  out  1  high while in PLAY.
REQ-018 done  out  1  one-cycle pulse on normal completion.

Function
REQ-019 FSM states SHALL be IDLE and PLAY only.
REQ-020 IDLE: start=1 and en=1 SHALL latch pat_sel, repeat_n, tone_mode, clear step, step_cnt, rep, tone_cnt, tone_phase and enter PLAY at the same edge.
REQ-021 start with en=0 SHALL be ignored.
REQ-022 PLAY: step_cnt SHALL count 0..STEP_CYCLES-1 and wrap; at wrap step SHALL increment.
REQ-023 At wrap with step=PAT_LEN-1: if rep==latched repeat_n, go IDLE and pulse done for one cycle; else rep+1, step 0.
REQ-024 start=1 in PLAY (en=1) SHALL retrigger: re-latch inputs, clear counters, stay PLAY, no done pulse.
REQ-025 Retrigger coinciding with the final wrap SHALL take priority; no done pulse.
REQ-026 en=0 in PLAY SHALL go IDLE at the next edge with no done pulse.
REQ-027 tone_cnt SHALL count 0..TONE_HALF-1 during PLAY; tone_phase toggles at each wrap; phase not reset at step boundaries.
REQ-028 Let bit = PATTERNS[sel*PAT_LEN+step] (0 if sel >= N_PAT); next beep_out = PLAY & en & ~mute & bit & (tone_mode ? tone_phase : 1).
REQ-029 beep_out SHALL lag the state/step it reflects by exactly one clk; first sound cycle is one cycle after the start edge.
REQ-030 busy SHALL equal (state==PLAY), registered with state.
REQ-031 Inputs other than en, mute, start SHALL be ignored in PLAY except when latched by start.
REQ-032 Counters SHALL be sized ceil(log2) of their limits; no overflow past limits; STEP_CYCLES and TONE_HALF >= 1.

Reset
REQ-033 rst=1 SHALL force IDLE and clear step, step_cnt, rep, tone_cnt, tone_phase and all latches; beep_out=0, busy=0, done=0 at the next edge.
REQ-034 rst SHALL override start, en and any simultaneous event, including mid-PLAY.

Verification (STEP_CYCLES=4, TONE_HALF=2, other parameters default)
REQ-035 Lose, level: start pat_sel=0, repeat_n=0, tone_mode=0 -> beep_out 1,1,1,1,0,0,0,0 repeating for 32 cycles; busy high 32 cycles; one done pulse on the last busy-to-idle edge.
REQ-036 Win, tone: pat_sel=1, tone_mode=1 -> beep_out 0 for 12 cycles, then 0,0,1,1 during step 3 and 0,0,1,1 during step 7; all other cycles 0.
REQ-037 Repeat: pat_sel=0, repeat_n=2 -> busy 96 cycles, lose pattern three times, exactly one done pulse.
REQ-038 Mute/abort: mute=1 during cycles 5-12 -> beep_out 0 there, done still at cycle 32. Separate run with en=0 at cycle 10 -> busy 0 at the next edge, beep_out 0, no done.
REQ-039 Retrigger/reset: start pat_sel=1 at cycle 20 of a lose play -> win pattern restarts from step 0 with no done pulse for the first play. rst at cycle 15 -> all outputs 0 at the next edge; a later start plays normally.

Source files
------------

// File: rtl/beep_pattern_player.sv
// beep_pattern_player
//   Plays one of N_PAT stored on/off patterns on a buzzer output.
//   Each pattern has PAT_LEN steps of STEP_CYCLES clocks. The whole pattern
//   is played repeat_n+1 times. In tone mode the "on" steps are gated with a
//   square wave of half-period TONE_HALF clocks.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   en            : sound enable; dropping it aborts a play (no done)
//   mute          : silences beep_out without disturbing sequencing
//   start         : one-cycle play request (also retriggers while playing)
//   pat_sel       : pattern index; indices >= N_PAT play silence
//   repeat_n      : extra plays after the first
//   tone_mode     : 0 = level output, 1 = gated square tone
//   beep_out      : registered buzzer drive (lags state/step by one clock)
//   busy          : high while playing
//   done          : one-cycle pulse when a play completes normally
module beep_pattern_player #(
   parameter int PAT_LEN     = 8,
   parameter int N_PAT       = 4,
   parameter int SEL_W       = 2,
   parameter logic [N_PAT*PAT_LEN-1:0] PATTERNS = {8'h00, 8'h00, 8'h88, 8'h55},
   parameter int STEP_CYCLES = 12500000,
   parameter int TONE_HALF   = 12500,
   parameter int REP_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mute,
   input  logic             start,
   input  logic [SEL_W-1:0] pat_sel,
   input  logic [REP_W-1:0] repeat_n,
   input  logic             tone_mode,
   output logic             beep_out,
   output logic             busy,
   output logic             done
);

   localparam int SC_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int TC_W   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam int STEP_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

   localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(STEP_CYCLES - 1);
   localparam logic [TC_W-1:0]   TC_LAST   = TC_W'(TONE_HALF - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PAT_LEN - 1);

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [REP_W-1:0]   rep_n_q, rep_n_d;
   logic               tone_mode_q, tone_mode_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [SC_W-1:0]    step_cnt_q, step_cnt_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [TC_W-1:0]    tone_cnt_q, tone_cnt_d;
   logic               tone_phase_q, tone_phase_d;
   logic               beep_q, beep_d;
   logic               done_q, done_d;

   logic [PAT_LEN-1:0] pat_row;
   logic               pat_bit;

   // Row lookup; unmatched selects (>= N_PAT) leave the row all zero.
   always_comb begin
      pat_row = '0;
      for (int p = 0; p < N_PAT; p++) begin
         if (sel_q == SEL_W'(p)) pat_row = PATTERNS[p*PAT_LEN +: PAT_LEN];
      end
      pat_bit = pat_row[step_q];
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      rep_n_d      = rep_n_q;
      tone_mode_d  = tone_mode_q;
      step_d       = step_q;
      step_cnt_d   = step_cnt_q;
      rep_d        = rep_q;
      tone_cnt_d   = tone_cnt_q;
      tone_phase_d = tone_phase_q;
      done_d       = 1'b0;

      if (en && start) begin
         // Fresh start and retrigger share one path; retrigger wins over
         // a coincident final wrap, so no done is raised here.
         state_d      = PLAY;
         sel_d        = pat_sel;
         rep_n_d      = repeat_n;
         tone_mode_d  = tone_mode;
         step_d       = '0;
         step_cnt_d   = '0;
         rep_d        = '0;
         tone_cnt_d   = '0;
         tone_phase_d = 1'b0;
      end else if (state_q == PLAY) begin
         if (!en) begin
            state_d = IDLE;
         end else begin
            // Tone runs freely across step boundaries.
            if (tone_cnt_q == TC_LAST) begin
               tone_cnt_d   = '0;
               tone_phase_d = ~tone_phase_q;
            end else begin
               tone_cnt_d = tone_cnt_q + 1'b1;
            end

            if (step_cnt_q == SC_LAST) begin
               step_cnt_d = '0;
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  if (rep_q == rep_n_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     rep_d = rep_q + 1'b1;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end else begin
               step_cnt_d = step_cnt_q + 1'b1;
            end
         end
      end

      // Output reflects the current state/step, hence one clock of lag.
      beep_d = (state_q == PLAY) & en & ~mute & pat_bit &
               (tone_mode_q ? tone_phase_q : 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         rep_n_q      <= '0;
         tone_mode_q  <= 1'b0;
         step_q       <= '0;
         step_cnt_q   <= '0;
         rep_q        <= '0;
         tone_cnt_q   <= '0;
         tone_phase_q <= 1'b0;
         beep_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         rep_n_q      <= rep_n_d;
         tone_mode_q  <= tone_mode_d;
         step_q       <= step_d;
         step_cnt_q   <= step_cnt_d;
         rep_q        <= rep_d;
         tone_cnt_q   <= tone_cnt_d;
         tone_phase_q <= tone_phase_d;
         beep_q       <= beep_d;
         done_q       <= done_d;
      end
   end

   assign beep_out = beep_q;
   assign busy     = (state_q == PLAY);
   assign done     = done_q;

endmodule

// File: tb/tb_beep_pattern_player.sv
// Directed bench for beep_pattern_player with STEP_CYCLES=4, TONE_HALF=2.
// Sample index n = number of rising edges since the edge that accepted start
// (n=0 is the negedge right after that edge). beep_out at sample n reflects
// play cycle n-1.
module tb_beep_pattern_player;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       mute = 1'b0;
   logic       start = 1'b0;
   logic [1:0] pat_sel = 2'd0;
   logic [3:0] repeat_n = 4'd0;
   logic       tone_mode = 1'b0;
   logic       beep_out, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   beep_pattern_player #(
      .STEP_CYCLES(4),
      .TONE_HALF  (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mute     (mute),
      .start    (start),
      .pat_sel  (pat_sel),
      .repeat_n (repeat_n),
      .tone_mode(tone_mode),
      .beep_out (beep_out),
      .busy     (busy),
      .done     (done)
   );

   // Reference: output level for play cycle c (c counted from the start edge).
   function automatic logic ref_lvl(input int sel, input int c, input logic tone);
      logic [7:0] p;
      logic       ph;
      p  = (sel == 0) ? 8'h55 : (sel == 1) ? 8'h88 : 8'h00;
      ph = ((c / 2) % 2) == 1;
      return p[3'((c / 4) % 8)] & (tone ? ph : 1'b1);
   endfunction

   task automatic kick(input logic [1:0] sel, input logic [3:0] rn, input logic tm);
      @(negedge clk);
      pat_sel = sel; repeat_n = rn; tone_mode = tm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (beep_out !== 1'b0) begin errors++; $display("FAIL reset_beep got %b exp 0", beep_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      rst = 1'b0;
   endtask

   task automatic test_start_no_en;
      en = 1'b0;
      kick(2'd0, 4'd0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_no_en_busy n=%0d got %b exp 0", n, busy); end
         @(negedge clk);
      end
      en = 1'b1;
   endtask

   // Plays a single pass of pattern sel and checks every sample.
   task automatic test_play(input string nm, input int sel, input logic tm);
      logic eb, ey, ed;
      kick(2'(sel), 4'd0, tm);
      for (int n = 0; n <= 34; n++) begin
         ey = (n <= 31);
         ed = (n == 32);
         eb = (n >= 1 && n <= 32) ? ref_lvl(sel, n - 1, tm) : 1'b0;
         checks++; if (beep_out !== eb) begin errors++; $display("FAIL %s_beep n=%0d got %b exp %b", nm, n, beep_out, eb); end
         checks++; if (busy !== ey) begin errors++; $display("FAIL %s_busy n=%0d got %b exp %b", nm, n, busy, ey); end
         checks++; if (done !== ed) begin errors++; $display("FAIL %s_done n=%0d got %b exp %b", nm, n, done, ed); end
         @(negedge clk);
      end
   endtask

   task automatic test_repeat;
      logic eb;
      int   dones = 0;
      kick(2'd0, 4'd2, 1'b0);
      for (int n = 0; n <= 98; n++) begin
         eb = (n >= 1 && n <= 96) ? ref_lvl(0, n - 1, 1'b0) : 1'b0;
         if (done === 1'b1) dones++;
         checks++; if (beep_out !== eb) begin errors++; $display("FAIL repeat_beep n=%0d got %b exp %b", n, beep_out, eb); end
         checks++; if (busy !== (n <= 95)) begin errors++; $display("FAIL repeat_busy n=%0d got %b exp %b", n, busy, n <= 95); end
         checks++; if (done !== (n == 96)) begin errors++; $display("FAIL repeat_done n=%0d got %b exp %b", n, done, n == 96); end
         @(negedge clk);
      end
      checks++; if (dones != 1) begin errors++; $display("FAIL repeat_done_count got %0d exp 1", dones); end
   endtask

   task automatic test_mute;
      logic eb;
      kick(2'd0, 4'd0, 1'b0);
      for (int n = 0; n <= 33; n++) begin
         eb = (n >= 1 && n <= 32 && !(n - 1 >= 5 && n - 1 <= 12)) ? ref_lvl(0, n - 1, 1'b0) : 1'b0;
         checks++; if (beep_out !== eb) begin errors++; $display("FAIL mute_beep n=%0d got %b exp %b", n, beep_out, eb); end
         checks++; if (done !== (n == 32)) begin errors++; $display("FAIL mute_done n=%0d got %b exp %b", n, done, n == 32); end
         mute = (n >= 5 && n <= 12);
         @(negedge clk);
      end
      mute = 1'b0;
   endtask

   task automatic test_abort;
      logic eb;
      kick(2'd0, 4'd0, 1'b0);
      for (int n = 0; n <= 14; n++) begin
         eb = (n >= 1 && n <= 10) ? ref_lvl(0, n - 1, 1'b0) : 1'b0;
         checks++; if (beep_out !== eb) begin errors++; $display("FAIL abort_beep n=%0d got %b exp %b", n, beep_out, eb); end
         checks++; if (busy !== (n <= 10)) begin errors++; $display("FAIL abort_busy n=%0d got %b exp %b", n, busy, n <= 10); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done n=%0d got %b exp 0", n, done); end
         if (n == 10) en = 1'b0;
         @(negedge clk);
      end
      en = 1'b1;
   endtask

   // Win pattern retriggers during cycle 20 of a lose play.
   task automatic test_retrigger;
      logic eb;
      kick(2'd0, 4'd0, 1'b0);
      for (int n = 0; n <= 55; n++) begin
         if (n <= 21)      eb = (n >= 1) ? ref_lvl(0, n - 1, 1'b0) : 1'b0;
         else if (n <= 53) eb = ref_lvl(1, n - 22, 1'b0);
         else              eb = 1'b0;
         checks++; if (beep_out !== eb) begin errors++; $display("FAIL retrig_beep n=%0d got %b exp %b", n, beep_out, eb); end
         checks++; if (busy !== (n <= 52)) begin errors++; $display("FAIL retrig_busy n=%0d got %b exp %b", n, busy, n <= 52); end
         checks++; if (done !== (n == 53)) begin errors++; $display("FAIL retrig_done n=%0d got %b exp %b", n, done, n == 53); end
         start = (n == 20);
         if (n == 20) pat_sel = 2'd1;
         @(negedge clk);
      end
   endtask

   // Retrigger landing exactly on the final wrap: no done, new play runs.
   task automatic test_back_to_back;
      logic eb;
      kick(2'd0, 4'd0, 1'b0);
      for (int n = 0; n <= 65; n++) begin
         if (n <= 32)      eb = (n >= 1) ? ref_lvl(0, n - 1, 1'b0) : 1'b0;
         else if (n <= 64) eb = ref_lvl(0, n - 33, 1'b0);
         else              eb = 1'b0;
         checks++; if (beep_out !== eb) begin errors++; $display("FAIL b2b_beep n=%0d got %b exp %b", n, beep_out, eb); end
         checks++; if (busy !== (n <= 63)) begin errors++; $display("FAIL b2b_busy n=%0d got %b exp %b", n, busy, n <= 63); end
         checks++; if (done !== (n == 64)) begin errors++; $display("FAIL b2b_done n=%0d got %b exp %b", n, done, n == 64); end
         start = (n == 31);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      kick(2'd0, 4'd0, 1'b0);
      for (int n = 0; n < 15; n++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (beep_out !== 1'b0) begin errors++; $display("FAIL rst_mid_beep got %b exp 0", beep_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
      rst = 1'b0;
      test_play("after_rst", 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_start_no_en();
      test_play("lose_level", 0, 1'b0);
      test_play("win_tone", 1, 1'b1);
      test_play("silent_sel", 3, 1'b0);
      test_repeat();
      test_mute();
      test_abort();
      test_retrigger();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
